// File: rtl/c6288_pkg.sv
// Shared widths for the c6288-style 16x16 unsigned array multiplier.
// Only the 16x16 configuration exists; the widths are named, not tunable.
package c6288_pkg;
    localparam int A_W = 16;
    localparam int B_W = 16;
    localparam int P_W = A_W + B_W;
endpackage

// File: rtl/c6288_fa.sv
// 1-bit gate-level full adder, the single cell the multiplier array is built from.
// Latency: combinational. Backpressure: none.
module c6288_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic axb;

    assign axb  = a ^ b;
    assign s    = axb ^ cin;
    assign cout = (a & b) | (cin & axb);
endmodule

// File: rtl/c6288_mult16.sv
// Unsigned 16x16 carry-save array multiplier (c6288 structure), product registered once.
// Latency: 1 cycle from in_valid to out_valid. Backpressure: none, accepts one pair per cycle.
module c6288_mult16
    import c6288_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [A_W-1:0] a_in,
    input  logic [B_W-1:0] b_in,
    output logic [P_W-1:0] p_out,
    output logic           out_valid
);
    logic [P_W-1:0] prod;

    // Row i carries sum bits s[j] of weight i+j and carries c[j] of weight i+j+1.
    // Row 0 is the bare partial product; its zero carries turn row 1 into half adders.
    for (genvar i = 0; i < B_W; i++) begin : g_row
        logic [A_W-1:0] pp;
        logic [A_W-1:0] s;
        logic [A_W-2:0] c;

        assign pp = a_in & {A_W{b_in[i]}};

        if (i == 0) begin : g_first
            assign s = pp;
            assign c = '0;
        end else begin : g_csa
            assign s[A_W-1] = pp[A_W-1];
            for (genvar j = 0; j < A_W-1; j++) begin : g_cell
                c6288_fa u_fa (
                    .a    (pp[j]),
                    .b    (g_row[i-1].s[j+1]),
                    .cin  (g_row[i-1].c[j]),
                    .s    (s[j]),
                    .cout (c[j])
                );
            end
        end

        assign prod[i] = s[0];
    end

    // Final ripple row merges the last sum/carry vectors into bits 16..31.
    for (genvar k = 0; k < A_W-1; k++) begin : g_fin
        logic ci;
        logic s;
        logic co;

        if (k == 0) begin : g_c0
            assign ci = 1'b0;
        end else begin : g_cn
            assign ci = g_fin[k-1].co;
        end

        c6288_fa u_fa (
            .a    (g_row[B_W-1].s[k+1]),
            .b    (g_row[B_W-1].c[k]),
            .cin  (ci),
            .s    (s),
            .cout (co)
        );

        assign prod[B_W+k] = s;
    end

    assign prod[P_W-1] = g_fin[A_W-2].co;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                p_out <= prod;
            end
        end
    end
endmodule

// File: tb/tb_c6288_mult16.sv
// Directed plus random bench for c6288_mult16 using an expected-product queue.
module tb_c6288_mult16;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [31:0] p_out;
    logic        out_valid;

    int          total;
    int          bad;
    logic [31:0] sb_q[$];
    logic [31:0] last_p;

    c6288_mult16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a_in      (a_in),
        .b_in      (b_in),
        .p_out     (p_out),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One cycle: present operands, clock, then check just after the edge.
    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b, input logic v);
        logic [31:0] e;
        a_in     = a;
        b_in     = b;
        in_valid = v;
        if (v) sb_q.push_back({16'h0, a} * {16'h0, b});
        @(posedge clk);
        #1;
        if (v) begin
            e = sb_q.pop_front();
            chk({tag, "_vld"}, {31'h0, out_valid}, 32'h1);
            chk({tag, "_p"}, p_out, e);
            last_p = e;
        end else begin
            chk({tag, "_vld"}, {31'h0, out_valid}, 32'h0);
            chk({tag, "_hold"}, p_out, last_p);
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rv;
        total    = 0;
        bad      = 0;
        last_p   = 32'h0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a_in     = 16'($urandom);
        b_in     = 16'($urandom);

        // Reset held with live operands and clock running.
        #2;
        chk("rst_p", p_out, 32'h0);
        chk("rst_vld", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_edge_p", p_out, 32'h0);
        chk("rst_edge_vld", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        step("zero", 16'h0000, 16'h0000, 1'b1);
        step("one_x_ffff", 16'h0001, 16'hFFFF, 1'b1);
        step("ffff_sq", 16'hFFFF, 16'hFFFF, 1'b1);
        chk("ffff_sq_const", p_out, 32'hFFFE0001);
        step("carry16", 16'h8000, 16'h0002, 1'b1);
        chk("carry16_const", p_out, 32'h00010000);
        step("dec", 16'd12345, 16'd6789, 1'b1);
        chk("dec_const", p_out, 32'h04FED79D);
        step("hold", 16'd3, 16'd5, 1'b0);
        chk("hold_const", p_out, 32'h04FED79D);

        // Reset asserted mid-cycle while a valid pair is being presented.
        step("pre_rst", 16'hABCD, 16'h1234, 1'b1);
        a_in     = 16'h7777;
        b_in     = 16'h9999;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_p", p_out, 32'h0);
        chk("mid_rst_vld", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_edge_p", p_out, 32'h0);
        chk("mid_rst_edge_vld", {31'h0, out_valid}, 32'h0);
        last_p = 32'h0;
        sb_q.delete();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step("post_rst_idle", 16'h1111, 16'h2222, 1'b0);
        step("post_rst", 16'hBEEF, 16'hCAFE, 1'b1);
        step("b2b", 16'hFFFF, 16'h0001, 1'b1);

        for (int n = 0; n < 10000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rv = ($urandom_range(0, 9) != 0);
            step("rand", ra, rb, rv);
        end

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/c6288_mult16.md
Name: c6288_mult16

Overview:
- Unsigned 16x16 array multiplier with the structure of the ISCAS-85 c6288 benchmark: AND-gate partial products, a carry-save adder array and a ripple final row.
- Serves as the circuit-under-test for the stuck-at fault-simulation and dictionary flow. Two instances are compared bit-for-bit: one golden, one with an injected fault.
- The product is registered once at the output, so the flow samples a stable 32-bit value.

Parameters:
- A_W, 16, multiplicand width. Fixed at 16; other values are not supported.
- B_W, 16, multiplier width. Fixed at 16.
- P_W, 32, product width. Always A_W+B_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  qualifies a_in/b_in this cycle.
- a_in  in  16  multiplicand, unsigned. Bit 0 is the LSB; maps to c6288 inputs 0..15.
- b_in  in  16  multiplier, unsigned. Bit 0 is the LSB; maps to c6288 inputs 16..31.
- p_out  out  32  registered product. Bit 0 is the LSB; maps to c6288 outputs 0..31.
- out_valid  out  1  p_out holds the product of the operands accepted on the previous edge.

Behaviour:
- Combinational core:
  - pp[i][j] = a_in[j] & b_in[i].
  - 15 rows of carry-save adders: half adders at row edges, full adders elsewhere.
  - Final ripple-carry row produces product bits 16..31.
  - Total 240 adder cells; every net is an explicit wire so stuck-at faults can be injected on it.
  - No behavioural "*" operator in the core.
- Arithmetic: p = a*b, unsigned, exact over the full 32 bits. No truncation, no overflow possible.
- Register stage:
  - On a clk rising edge with in_valid=1: p_out <= core product, out_valid <= 1.
  - On a clk rising edge with in_valid=0: p_out holds its value, out_valid <= 0.
- Latency: 1 cycle from an accepted operand pair to valid output. Throughput: one product per cycle; back-to-back in_valid is supported.
- Reset: when rst_n falls, p_out=0 and out_valid=0 immediately, independent of clk. Reset asserted mid-stream discards any in-flight operand. The first edge after deassertion behaves as a normal cycle.
- Combinational settle: the core must settle within one clock period. The fault flow runs a period of at least 60 ns; no timing constraint is tighter than that.
- X handling: X on an operand bit propagates naturally through the gates; no masking.
- No internal state other than p_out and out_valid.

Decomposition:
- Package c6288_pkg holds A_W, B_W, P_W as localparams.
- Sub-module c6288_fa: a 1-bit full adder (a, b, cin -> s, cout), built from gates. The array is generated from it.
- Half adders are plain XOR/AND inside the top level, or c6288_fa with cin tied to 0.
- The top level contains the partial-product generate, the adder array generate, and the output register.

Test Plan:
- Reset: hold rst_n=0 with random operands -> p_out=0x00000000 and out_valid=0; rst_n is asynchronous, so the clear happens before the next clk edge.
- Corners, one per cycle with in_valid=1: a=0,b=0 -> 0; a=1,b=0xFFFF -> 0x0000FFFF; a=0xFFFF,b=0xFFFF -> 0xFFFE0001. Each appears one cycle later with out_valid=1.
- Carry chain: a=0x8000,b=0x0002 -> 0x00010000; a=12345,b=6789 -> 83810205 (0x04FED79D).
- Hold behaviour: drop in_valid with new operands a=3,b=5 -> p_out keeps its previous value and out_valid=0.
- Reset mid-stream: assert rst_n low between two valid inputs -> outputs clear at once; the next valid pair after release gives the correct product one cycle later.
- Random regression: 10,000 random pairs against a*b -> zero mismatches.
